multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
Multi-cycle instruction sequencer for the R-type RISC-V core. It fetches instructions over a simple request/ready instruction-memory handshake and holds each one in an instruction register. It exposes the opcode/funct3/funct7 fields to the existing combinational control decoder, then steps the ALU and register-file write through DECODE, EXECUTE and WRITEBACK. It owns the PC, the retired-instruction counter and fault trapping.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FETCH_TIMEOUT, 8, maximum FETCH cycles without imem_ready before a fetch fault; 0 disables the timeout.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  level; leaves IDLE and starts fetching at the current pc.
halt_req  in  1  stop at the next instruction boundary; sampled only in WRITEBACK.
imem_req  out  1  fetch request; high throughout FETCH.
imem_addr  out  32  equals pc while imem_req is high, else 0.
imem_ready  in  1  imem_rdata is valid this cycle; the request is complete.
imem_rdata  in  32  instruction word.
opcode  out  7  IR[6:0].
funct3  out  3  IR[14:12].
funct7  out  7  IR[31:25].
rs1  out  5  IR[19:15].
rs2  out  5  IR[24:20].
rd  out  5  IR[11:7].
regwrite_control  in  1  decoder "legal R-type" flag.
alu_control_in  in  4  decoder ALU code.
alu_control  out  4  ALU code latched in DECODE and held until the next DECODE.
reg_write_en  out  1  one-cycle register-file write strobe.
pc  out  32  program counter.
retired_count  out  32  count of instructions completed.
busy  out  1  high in FETCH, DECODE, EXECUTE and WRITEBACK.
fault_cause  out  2  00 none, 01 illegal instruction, 10 fetch timeout.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pc=RESET_PC, IR=0, alu_control=0, retired_count=0, timeout counter=0, fault_cause=00.
  - imem_req, reg_write_en and busy drop in the same cycle reset asserts, with no clock edge needed.
  - Reset in any state, including mid-fetch, abandons the instruction with no write and no count.
- All outputs are registered or decoded from state/IR only; there is no combinational path from any input to any output.
- IDLE:
  - start=1 moves to FETCH; otherwise stay.
  - halt_req is ignored here.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_ready=1: IR<=imem_rdata, clear the timeout counter, go to DECODE.
  - Otherwise increment the timeout counter. When FETCH_TIMEOUT!=0 and the counter reaches FETCH_TIMEOUT, go to TRAP with fault_cause=10.
  - Result: ready on cycle N of FETCH (N=1..FETCH_TIMEOUT) succeeds; ready never arriving traps on the edge after the FETCH_TIMEOUT-th FETCH cycle.
- DECODE:
  - The decoder sees the IR fields.
  - regwrite_control=0: go to TRAP with fault_cause=01. Registered alu_control is unchanged.
  - regwrite_control=1: alu_control<=alu_control_in, go to EXECUTE.
- EXECUTE: single cycle for the ALU to settle on the register-file outputs; go to WRITEBACK.
- WRITEBACK:
  - reg_write_en=1 only when rd!=0; an x0 write is suppressed.
  - pc<=pc+4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0).
  - retired_count<=retired_count+1, wrapping mod 2^32. Counts every retired instruction, including rd=0.
  - Next state: halt_req=1 goes to IDLE; otherwise FETCH.
- TRAP: absorbing state; only reset leaves it. busy=0, imem_req=0, and pc holds the address of the faulting instruction.
- Throughput: 4 cycles per instruction with zero-wait memory (FETCH, DECODE, EXECUTE, WRITEBACK); each FETCH wait cycle adds 1.
- Simultaneous events:
  - start and halt_req both high in WRITEBACK: halt wins, and the block then leaves IDLE on the next edge because start is still high.
  - imem_ready on the same cycle the timeout would expire: the fetch succeeds; ready has priority.
- imem_ready outside FETCH is ignored.

Test Plan:
- Zero-wait ADD: reset, start=1, imem_ready=1, imem_rdata=32'h002081B3 -> imem_addr=0. DECODE shows opcode=0110011, funct3=0, funct7=0, rs1=1, rs2=2, rd=3. reg_write_en pulses exactly once, 3 cycles after FETCH. pc=4, retired_count=1, and the next FETCH has imem_addr=4.
- Wait states: imem_ready low for 3 FETCH cycles then high with the same word -> no fault, and reg_write_en is delayed by exactly 3 cycles compared with the zero-wait ADD case.
- Illegal: imem_rdata=32'h00000013 (addi), decoder regwrite_control=0 -> TRAP with fault_cause=01, busy=0, pc=0, reg_write_en never asserts, retired_count=0. start has no effect until reset.
- Fetch timeout with FETCH_TIMEOUT=8: imem_ready held low -> TRAP with fault_cause=10 after 8 FETCH cycles. Repeat with ready arriving in the 8th FETCH cycle -> normal completion.
- x0 and halt:
  - Run 32'h00208033 (add x0,x1,x2) -> no reg_write_en, retired_count increments.
  - Assert halt_req during the second instruction's WRITEBACK -> IDLE, busy=0, pc=8.
  - start=1 -> fetch resumes at imem_addr=8.
- Reset mid-op: assert reset during EXECUTE, between clock edges -> imem_req/busy/reg_write_en drop immediately. pc=RESET_PC, retired_count=0, state IDLE, no write strobe.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// ============================================================================
// Module   : multicycle_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the
//            R-type core; owns PC, retired counter and fault trapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_sequencer #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int unsigned FETCH_TIMEOUT = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        halt_req,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   input  logic        regwrite_control,
   input  logic [3:0]  alu_control_in,
   output logic [3:0]  alu_control,
   output logic        reg_write_en,
   output logic [31:0] pc,
   output logic [31:0] retired_count,
   output logic        busy,
   output logic [1:0]  fault_cause
);

   localparam logic [31:0] C_TIMEOUT       = 32'(FETCH_TIMEOUT);
   localparam logic [1:0]  C_FAULT_NONE    = 2'b00;
   localparam logic [1:0]  C_FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0]  C_FAULT_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_WRITEBACK = 3'd4,
      S_TRAP      = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [3:0]  alu_q, alu_d;
   logic [31:0] retired_q, retired_d;
   logic [31:0] tmo_q, tmo_d;
   logic [1:0]  fault_q, fault_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         ir_q      <= 32'd0;
         alu_q     <= 4'd0;
         retired_q <= 32'd0;
         tmo_q     <= 32'd0;
         fault_q   <= C_FAULT_NONE;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         alu_q     <= alu_d;
         retired_q <= retired_d;
         tmo_q     <= tmo_d;
         fault_q   <= fault_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      alu_d     = alu_q;
      retired_d = retired_q;
      tmo_d     = tmo_q;
      fault_d   = fault_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            // ready wins over an expiring timeout on the same cycle
            if (imem_ready) begin
               ir_d    = imem_rdata;
               tmo_d   = 32'd0;
               state_d = S_DECODE;
            end else begin
               tmo_d = tmo_q + 32'd1;
               if ((C_TIMEOUT != 32'd0) && (tmo_d == C_TIMEOUT)) begin
                  state_d = S_TRAP;
                  fault_d = C_FAULT_TIMEOUT;
               end
            end
         end
         S_DECODE: begin
            if (regwrite_control) begin
               alu_d   = alu_control_in;
               state_d = S_EXECUTE;
            end else begin
               state_d = S_TRAP;
               fault_d = C_FAULT_ILLEGAL;
            end
         end
         S_EXECUTE: begin
            state_d = S_WRITEBACK;
         end
         S_WRITEBACK: begin
            pc_d      = pc_q + 32'd4;
            retired_d = retired_q + 32'd1;
            state_d   = halt_req ? S_IDLE : S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Strobes decode from state only so reset removes them without a clock edge
   assign imem_req      = (state_q == S_FETCH);
   assign imem_addr     = imem_req ? pc_q : 32'd0;
   assign busy          = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                          (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
   assign reg_write_en  = (state_q == S_WRITEBACK) && (ir_q[11:7] != 5'd0);

   assign opcode        = ir_q[6:0];
   assign funct3        = ir_q[14:12];
   assign funct7        = ir_q[31:25];
   assign rs1           = ir_q[19:15];
   assign rs2           = ir_q[24:20];
   assign rd            = ir_q[11:7];

   assign alu_control   = alu_q;
   assign pc            = pc_q;
   assign retired_count = retired_q;
   assign fault_cause   = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ============================================================================
// Module   : tb_multicycle_sequencer
// Brief    : Directed self-checking bench for multicycle_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_sequencer;

   localparam logic [31:0] C_ADD   = 32'h0020_81B3;
   localparam logic [31:0] C_ADDX0 = 32'h0020_8033;
   localparam logic [31:0] C_ADDI  = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        halt_req;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic        regwrite_control;
   logic [3:0]  alu_control_in;
   logic [3:0]  alu_control;
   logic        reg_write_en;
   logic [31:0] pc;
   logic [31:0] retired_count;
   logic        busy;
   logic [1:0]  fault_cause;

   int errors = 0;
   int checks = 0;
   int wait_cnt;

   multicycle_sequencer #(
      .RESET_PC      (32'h0000_0000),
      .FETCH_TIMEOUT (8)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .start            (start),
      .halt_req         (halt_req),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ready       (imem_ready),
      .imem_rdata       (imem_rdata),
      .opcode           (opcode),
      .funct3           (funct3),
      .funct7           (funct7),
      .rs1              (rs1),
      .rs2              (rs2),
      .rd               (rd),
      .regwrite_control (regwrite_control),
      .alu_control_in   (alu_control_in),
      .alu_control      (alu_control),
      .reg_write_en     (reg_write_en),
      .pc               (pc),
      .retired_count    (retired_count),
      .busy             (busy),
      .fault_cause      (fault_cause)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; halt_req = 1'b0; imem_ready = 1'b0;
      imem_rdata = 32'd0; regwrite_control = 1'b0; alu_control_in = 4'd0;

      // Reset state
      step(); step();
      chk("rst_pc", pc, 32'd0);
      chk("rst_retired", retired_count, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_fault", {30'd0, fault_cause}, 32'd0);
      chk("rst_ir", {25'd0, opcode}, 32'd0);
      chk("rst_alu", {28'd0, alu_control}, 32'd0);
      reset = 1'b0;

      // Zero-wait ADD
      start = 1'b1; imem_ready = 1'b1; imem_rdata = C_ADD;
      regwrite_control = 1'b1; alu_control_in = 4'h2;
      step();
      chk("add_fetch_req", {31'd0, imem_req}, 32'd1);
      chk("add_fetch_addr", imem_addr, 32'd0);
      chk("add_fetch_busy", {31'd0, busy}, 32'd1);
      start = 1'b0;
      step();
      chk("add_dec_opcode", {25'd0, opcode}, 32'h33);
      chk("add_dec_f3", {29'd0, funct3}, 32'd0);
      chk("add_dec_f7", {25'd0, funct7}, 32'd0);
      chk("add_dec_rs1", {27'd0, rs1}, 32'd1);
      chk("add_dec_rs2", {27'd0, rs2}, 32'd2);
      chk("add_dec_rd", {27'd0, rd}, 32'd3);
      chk("add_dec_wen", {31'd0, reg_write_en}, 32'd0);
      chk("add_dec_req", {31'd0, imem_req}, 32'd0);
      step();
      chk("add_exe_alu", {28'd0, alu_control}, 32'h2);
      chk("add_exe_wen", {31'd0, reg_write_en}, 32'd0);
      alu_control_in = 4'h7;
      step();
      chk("add_wb_wen", {31'd0, reg_write_en}, 32'd1);
      chk("add_wb_alu_hold", {28'd0, alu_control}, 32'h2);
      imem_ready = 1'b0;
      step();
      chk("add_next_wen", {31'd0, reg_write_en}, 32'd0);
      chk("add_next_pc", pc, 32'd4);
      chk("add_next_retired", retired_count, 32'd1);
      chk("add_next_addr", imem_addr, 32'd4);

      // Three FETCH wait cycles delay the write strobe by exactly 3
      wait_cnt = 0;
      while (!reg_write_en && wait_cnt < 20) begin
         if (wait_cnt == 1) begin
            chk("ws_req_hold", {31'd0, imem_req}, 32'd1);
            chk("ws_addr_hold", imem_addr, 32'd4);
         end
         if (wait_cnt == 3) imem_ready = 1'b1;
         step();
         wait_cnt++;
      end
      chk("ws_latency", wait_cnt, 32'd6);
      chk("ws_fault", {30'd0, fault_cause}, 32'd0);
      imem_ready = 1'b0;
      step();
      chk("ws_pc", pc, 32'd8);
      chk("ws_retired", retired_count, 32'd2);
      chk("ws_addr", imem_addr, 32'd8);

      // Reset between edges while in EXECUTE
      imem_ready = 1'b1; imem_rdata = C_ADD;
      step();
      step();
      chk("mid_exe_busy", {31'd0, busy}, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("mid_req", {31'd0, imem_req}, 32'd0);
      chk("mid_busy", {31'd0, busy}, 32'd0);
      chk("mid_wen", {31'd0, reg_write_en}, 32'd0);
      chk("mid_pc", pc, 32'd0);
      chk("mid_retired", retired_count, 32'd0);
      step();
      reset = 1'b0;
      step(); step();
      chk("mid_idle_busy", {31'd0, busy}, 32'd0);
      chk("mid_idle_wen", {31'd0, reg_write_en}, 32'd0);
      chk("mid_idle_retired", retired_count, 32'd0);

      // add x0 then halt on the second instruction's WRITEBACK
      start = 1'b1; imem_ready = 1'b1; imem_rdata = C_ADDX0;
      step();
      chk("x0_addr", imem_addr, 32'd0);
      start = 1'b0;
      step();
      chk("x0_rd", {27'd0, rd}, 32'd0);
      step();
      step();
      chk("x0_wb_busy", {31'd0, busy}, 32'd1);
      chk("x0_wb_wen", {31'd0, reg_write_en}, 32'd0);
      imem_rdata = C_ADD;
      step();
      chk("x0_retired", retired_count, 32'd1);
      chk("x0_next_addr", imem_addr, 32'd4);
      step(); step(); step();
      chk("h_wb_wen", {31'd0, reg_write_en}, 32'd1);
      halt_req = 1'b1; start = 1'b1;
      step();
      chk("h_idle_busy", {31'd0, busy}, 32'd0);
      chk("h_idle_req", {31'd0, imem_req}, 32'd0);
      chk("h_pc", pc, 32'd8);
      chk("h_retired", retired_count, 32'd2);
      halt_req = 1'b0; imem_ready = 1'b0;
      step();
      chk("h_resume_req", {31'd0, imem_req}, 32'd1);
      chk("h_resume_addr", imem_addr, 32'd8);
      start = 1'b0;

      // Illegal instruction traps
      do_reset();
      start = 1'b1; imem_ready = 1'b1; imem_rdata = C_ADDI;
      regwrite_control = 1'b0; alu_control_in = 4'h5;
      step();
      step();
      chk("ill_dec_wen", {31'd0, reg_write_en}, 32'd0);
      step();
      chk("ill_fault", {30'd0, fault_cause}, 32'd1);
      chk("ill_busy", {31'd0, busy}, 32'd0);
      chk("ill_req", {31'd0, imem_req}, 32'd0);
      chk("ill_pc", pc, 32'd0);
      chk("ill_retired", retired_count, 32'd0);
      chk("ill_alu", {28'd0, alu_control}, 32'd0);
      regwrite_control = 1'b1;
      step(); step(); step(); step();
      chk("ill_stuck_fault", {30'd0, fault_cause}, 32'd1);
      chk("ill_stuck_busy", {31'd0, busy}, 32'd0);
      chk("ill_stuck_wen", {31'd0, reg_write_en}, 32'd0);
      chk("ill_stuck_retired", retired_count, 32'd0);
      start = 1'b0;

      // Fetch timeout after 8 FETCH cycles
      do_reset();
      start = 1'b1; imem_ready = 1'b0;
      step();
      start = 1'b0;
      repeat (7) step();
      chk("to_c8_busy", {31'd0, busy}, 32'd1);
      chk("to_c8_fault", {30'd0, fault_cause}, 32'd0);
      step();
      chk("to_fault", {30'd0, fault_cause}, 32'd2);
      chk("to_busy", {31'd0, busy}, 32'd0);
      chk("to_req", {31'd0, imem_req}, 32'd0);
      chk("to_pc", pc, 32'd0);

      // Ready in the 8th FETCH cycle still succeeds
      do_reset();
      start = 1'b1; imem_ready = 1'b0; imem_rdata = C_ADD;
      regwrite_control = 1'b1; alu_control_in = 4'h3;
      step();
      start = 1'b0;
      repeat (7) step();
      imem_ready = 1'b1;
      step();
      chk("t8_fault", {30'd0, fault_cause}, 32'd0);
      chk("t8_busy", {31'd0, busy}, 32'd1);
      chk("t8_rd", {27'd0, rd}, 32'd3);
      step();
      step();
      chk("t8_wen", {31'd0, reg_write_en}, 32'd1);
      step();
      chk("t8_pc", pc, 32'd4);
      chk("t8_retired", retired_count, 32'd1);
      chk("t8_alu", {28'd0, alu_control}, 32'h3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
